fir_output_decimator: RTL and testbench
=======================================

// Module: fir_output_decimator
// PURPOSE
//   Downstream stage of fir_filter. Takes the filter's signed output sample stream y,
//   keeps one sample in every DECIM, then scales it by an arithmetic right shift and saturates it.
//   Kept samples are buffered in a DEPTH-entry FIFO and handed off over a valid/ready interface.
//   Dropped samples (FIFO full) raise a sticky overflow flag.
// PARAMETERS
//   IN_W   32  width of in_data; matches fir_filter y
//   OUT_W  16  width of out_data; 2 <= OUT_W <= IN_W
//   DECIM  4   decimation factor; 1 = keep every sample
//   SHIFT  0   arithmetic right shift applied before saturation; 0..IN_W-1
//   DEPTH  8   FIFO entries; power of two, >= 2
// PORTS
//   clk       in   1                   rising-edge clock, shared with fir_filter
//   reset     in   1                   asynchronous, active-low reset
//   in_data   in   IN_W signed         sample from fir_filter y
//   in_valid  in   1                   in_data valid this cycle; tie 1 when fed directly by fir_filter
//   out_data  out  OUT_W signed        FIFO head sample
//   out_valid out  1                   FIFO non-empty
//   out_ready in   1                   consumer accepts head this cycle
//   level     out  $clog2(DEPTH)+1     FIFO occupancy, 0..DEPTH
//   overflow  out  1                   sticky; set when a kept sample is dropped
// BEHAVIOUR
//   Reset (reset==0, asynchronous):
//   - phase counter, FIFO pointers, level=0, out_valid=0, out_data=0, overflow=0.
//   - Reset mid-operation discards all buffered samples.
//   - On release, the first valid sample is phase 0.
//   Phase counter (0..DECIM-1):
//   - Advances only on cycles with in_valid=1, wrapping DECIM-1 -> 0.
//   - A sample is "kept" when in_valid=1 and phase==0. in_valid=0 cycles neither keep nor advance.
//   Scaling:
//   - s = in_data >>> SHIFT, arithmetic, computed at full IN_W width.
//   - If s > 2^(OUT_W-1)-1, the result is 2^(OUT_W-1)-1.
//   - If s < -2^(OUT_W-1), the result is -2^(OUT_W-1).
//   - Otherwise the result is the low OUT_W bits of s.
//   FIFO:
//   - push = kept & (level<DEPTH | pop); pop = out_valid & out_ready.
//   - A kept sample is written on the clock edge it is presented.
//   - out_valid and level update on that same edge, so latency from in_data to out_valid is 1 cycle.
//   - out_data is always mem[rd_ptr] and stays stable while out_valid=1 and out_ready=0.
//   - Simultaneous push & pop: when full, both succeed and level stays at DEPTH.
//     When empty, there is no pop; the push succeeds and level becomes 1.
//   - Kept sample with level==DEPTH and no pop: the sample is dropped, overflow<=1,
//     and the phase counter still advances.
//   - out_ready while out_valid=0 is ignored. Pointers wrap modulo DEPTH.
//   - overflow is cleared only by reset.
// CONFIGURATION
//   FIR_DECIM_ROUND_EN
//   - Defined: round-half-up before the shift.
//     s = (in_data + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, with the add at IN_W+1 bits so it cannot wrap.
//   - Undefined: truncate, i.e. s = in_data >>> SHIFT.
//   - Saturation is identical in both builds.
// TESTING
//   1 DECIM=2, SHIFT=0, out_ready=1, in_valid=1; in 3,-5,7,-9,11,-13
//     -> out_data 3,7,11, each one cycle after its input.
//   2 DECIM=1, OUT_W=16; in 40000, -40000, 1234 -> out 32767, -32768, 1234.
//   3 DECIM=1, SHIFT=2; in 7, -5
//     -> FIR_DECIM_ROUND_EN defined: 2, -1. Undefined: 1, -2.
//   4 DECIM=1, DEPTH=8, out_ready=0; push 10 samples 1..10
//     -> level=8, overflow=1 after the 9th, out_data=1.
//     Then out_ready=1 -> out 1..8 in order, level returns to 0.
//   5 Full FIFO, hold out_ready=1 and keep pushing -> level stays 8, overflow stays 0, no sample lost.
//   6 Assert reset for one cycle with level=5 and DECIM=4 at phase 2
//     -> level=0, out_valid=0, overflow=0; the next valid sample is kept.

Source files
------------

// File: rtl/fir_output_decimator.sv
// Decimating, scaling and saturating output stage for fir_filter with a valid/ready FIFO.
// Optional build macro FIR_DECIM_ROUND_EN selects round-half-up before the shift (default truncates).
module fir_output_decimator #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int DECIM = 4,
  parameter int SHIFT = 0,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [IN_W-1:0]     in_data,
  input  logic                       in_valid,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

  // Saturation bounds held at IN_W+1 bits so they compare directly with the shifted value.
  localparam logic signed [IN_W:0] MAX_V = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic [PW-1:0]           phase;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic signed [OUT_W-1:0] mem [DEPTH];
  logic signed [IN_W:0]    ext;
  logic signed [IN_W:0]    shifted;
  logic signed [OUT_W-1:0] sat;
  logic                    kept;
  logic                    full;
  logic                    pop;
  logic                    push;

`ifdef FIR_DECIM_ROUND_EN
  localparam logic signed [IN_W:0] RND =
    (SHIFT > 0) ? ((IN_W + 1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`endif

  always_comb begin
`ifdef FIR_DECIM_ROUND_EN
    ext = {in_data[IN_W-1], in_data} + RND;
`else
    ext = {in_data[IN_W-1], in_data};
`endif
    shifted = ext >>> SHIFT;
    if (shifted > MAX_V)
      sat = {1'b0, {(OUT_W - 1){1'b1}}};
    else if (shifted < MIN_V)
      sat = {1'b1, {(OUT_W - 1){1'b0}}};
    else
      sat = shifted[OUT_W-1:0];
  end

  always_comb begin
    kept      = in_valid && (phase == '0);
    full      = (level == LVL_FULL);
    out_valid = (level != '0);
    pop       = out_valid && out_ready;
    push      = kept && (!full || pop);
    out_data  = mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (in_valid) phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      if (push) begin
        mem[wr_ptr] <= sat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        level <= level + 1'b1;
      else if (pop && !push)
        level <= level - 1'b1;
      if (kept && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_output_decimator.sv
// Scoreboard bench for fir_output_decimator: four instances with different DECIM/SHIFT,
// directed stimulus pushes expected samples, a forked monitor pops and compares on handshake.
module tb_fir_output_decimator;

  localparam int N = 4;
  localparam int DEC_T [N] = '{2, 1, 1, 4};
  localparam int SH_T  [N] = '{0, 0, 2, 0};

  logic               clk;
  logic               rst       [N];
  logic signed [31:0] in_data   [N];
  logic               in_valid  [N];
  logic signed [15:0] out_data  [N];
  logic               out_valid [N];
  logic               out_ready [N];
  logic [3:0]         level     [N];
  logic               overflow  [N];

  int exp_q [N][$];
  int n_vec;
  int n_err;

  for (genvar g = 0; g < N; g++) begin : g_dut
    fir_output_decimator #(
      .IN_W (32),
      .OUT_W(16),
      .DECIM(DEC_T[g]),
      .SHIFT(SH_T[g]),
      .DEPTH(8)
    ) u_dut (
      .clk      (clk),
      .reset    (rst[g]),
      .in_data  (in_data[g]),
      .in_valid (in_valid[g]),
      .out_data (out_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .level    (level[g]),
      .overflow (overflow[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic drain(input int i);
    in_valid[i]  = 1'b0;
    out_ready[i] = 1'b1;
    for (int c = 0; c < 20 && level[i] != 0; c++) step();
    chk($sformatf("drain%0d_level", i), int'(level[i]), 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b0; in_data[i] = '0; in_valid[i] = 1'b0; out_ready[i] = 1'b0;
    end

    // Monitor: every accepted head sample must match the oldest expected one.
    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
          if (out_valid[i] && out_ready[i]) begin
            n_vec++;
            if (exp_q[i].size() == 0) begin
              n_err++;
              $display("FAIL mon%0d unexpected out_data: got %0d expected none", i, out_data[i]);
            end else begin
              automatic int e = exp_q[i].pop_front();
              if (int'(out_data[i]) != e) begin
                n_err++;
                $display("FAIL mon%0d out_data: got %0d expected %0d", i, out_data[i], e);
              end
            end
          end
        end
      end
    join_none

    step(); step();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst%0d_level", i), int'(level[i]), 0);
      chk($sformatf("rst%0d_out_valid", i), int'(out_valid[i]), 0);
      chk($sformatf("rst%0d_out_data", i), int'(out_data[i]), 0);
      chk($sformatf("rst%0d_overflow", i), int'(overflow[i]), 0);
      rst[i] = 1'b1;
    end
    step();

    // Decimate by 2: keep 3,7,11; out_valid one cycle after each kept input.
    begin
      int v [6] = '{3, -5, 7, -9, 11, -13};
      out_ready[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
        in_data[0] = v[k]; in_valid[0] = 1'b1;
        if (k % 2 == 0) exp_q[0].push_back(v[k]);
        step();
        chk($sformatf("t1_out_valid_%0d", k), int'(out_valid[0]), (k % 2 == 0) ? 1 : 0);
      end
      in_valid[0] = 1'b0;
      step();
    end

    // Saturation at OUT_W=16.
    begin
      int v [6] = '{40000, -40000, 1234, 32767, 32768, -32768};
      int e [6] = '{32767, -32768, 1234, 32767, 32767, -32768};
      out_ready[1] = 1'b1;
      for (int k = 0; k < 6; k++) begin
        in_data[1] = v[k]; in_valid[1] = 1'b1;
        exp_q[1].push_back(e[k]);
        step();
      end
      in_valid[1] = 1'b0;
      step();
    end

    // Shift by 2, truncation or round-half-up depending on build.
    begin
`ifdef FIR_DECIM_ROUND_EN
      int e [5] = '{2, -1, 32767, -32768, 32767};
`else
      int e [5] = '{1, -2, 32767, -32768, 32767};
`endif
      int v [5] = '{7, -5, 131068, -131072, 131075};
      out_ready[2] = 1'b1;
      for (int k = 0; k < 5; k++) begin
        in_data[2] = v[k]; in_valid[2] = 1'b1;
        exp_q[2].push_back(e[k]);
        step();
      end
      in_valid[2] = 1'b0;
      step();
    end

    // Fill past capacity with out_ready low: 9th and 10th dropped, overflow sticks.
    out_ready[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      in_data[1] = k; in_valid[1] = 1'b1;
      if (k <= 8) exp_q[1].push_back(k);
      step();
      if (k == 8) begin
        chk("t4_level_full", int'(level[1]), 8);
        chk("t4_overflow_before", int'(overflow[1]), 0);
      end
      if (k == 9) chk("t4_overflow_after", int'(overflow[1]), 1);
    end
    chk("t4_level_after10", int'(level[1]), 8);
    chk("t4_head", int'(out_data[1]), 1);
    step();
    chk("t4_head_stable", int'(out_data[1]), 1);
    drain(1);
    chk("t4_overflow_sticky", int'(overflow[1]), 1);

    // Full FIFO with simultaneous push and pop: no loss, no overflow.
    rst[1] = 1'b0;
    step();
    rst[1] = 1'b1;
    out_ready[1] = 1'b0;
    for (int k = 21; k <= 28; k++) begin
      in_data[1] = k; in_valid[1] = 1'b1;
      exp_q[1].push_back(k);
      step();
    end
    chk("t5_level_full", int'(level[1]), 8);
    out_ready[1] = 1'b1;
    for (int k = 29; k <= 40; k++) begin
      in_data[1] = k; in_valid[1] = 1'b1;
      exp_q[1].push_back(k);
      step();
      chk($sformatf("t5_level_%0d", k), int'(level[1]), 8);
    end
    chk("t5_overflow", int'(overflow[1]), 0);
    drain(1);

    // DECIM=4: 18 valid samples with idle gaps -> 5 kept, phase 2; then async reset.
    out_ready[3] = 1'b0;
    for (int k = 0; k < 18; k++) begin
      in_data[3] = 100 + k; in_valid[3] = 1'b1;
      if (k % 4 == 0) exp_q[3].push_back(100 + k);
      step();
      if (k % 2 == 1) begin
        in_data[3] = 999; in_valid[3] = 1'b0;
        step();
      end
    end
    in_valid[3] = 1'b0;
    chk("t6_level_pre", int'(level[3]), 5);
    rst[3] = 1'b0;
    #1;
    chk("t6_async_level", int'(level[3]), 0);
    chk("t6_async_out_valid", int'(out_valid[3]), 0);
    chk("t6_async_overflow", int'(overflow[3]), 0);
    exp_q[3].delete();
    step();
    rst[3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data[3] = 555 + k; in_valid[3] = 1'b1;
      if (k % 4 == 0) exp_q[3].push_back(555 + k);
      step();
      if (k == 0) chk("t6_first_kept", int'(level[3]), 1);
    end
    chk("t6_level_post", int'(level[3]), 2);
    drain(3);

    for (int i = 0; i < N; i++) begin
      drain(i);
      chk($sformatf("sb%0d_empty", i), exp_q[i].size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
